// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one memory port between fetch and LSU with in-order owner-tag response routing
module imem_port_arbiter #(
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid_i,
    output logic        if_req_ready_o,
    input  logic [31:0] if_addr_i,
    output logic        if_rsp_valid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_valid_i,
    output logic        ls_req_ready_o,
    input  logic [31:0] ls_addr_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_wstrb_i,
    output logic        ls_rsp_valid_o,
    output logic [31:0] ls_rdata_o,
    input  logic        flush_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int AW = $clog2(MAX_OUTST);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Tag FIFO: one owner bit (1 = LSU) and one drop bit per outstanding request.
    logic [MAX_OUTST-1:0] tag_ls;
    logic [MAX_OUTST-1:0] tag_drop;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        starve_cnt;
    logic                 lock;
    logic                 lock_ls;

    logic fifo_full;
    logic grant_ls;
    logic req_valid;
    logic issue;
    logic pop;
    logic head_ls;
    logic head_drop;

    always_comb begin
        fifo_full = (count == CW'(MAX_OUTST));
        if (lock) begin
            grant_ls = lock_ls;
        end else begin
            grant_ls = ls_req_valid_i &
                       ~(if_req_valid_i & (starve_cnt == SW'(STARVE_LIMIT)));
        end
        req_valid       = grant_ls ? ls_req_valid_i : if_req_valid_i;
        mem_req_valid_o = req_valid & ~fifo_full;
        issue           = mem_req_valid_o & mem_req_ready_i;
        if_req_ready_o  = ~grant_ls & mem_req_ready_i & ~fifo_full;
        ls_req_ready_o  =  grant_ls & mem_req_ready_i & ~fifo_full;

        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (mem_req_valid_o) begin
            if (grant_ls) begin
                mem_addr_o  = ls_addr_i;
                mem_we_o    = ls_we_i;
                mem_wdata_o = ls_wdata_i;
                mem_wstrb_o = ls_wstrb_i;
            end else begin
                mem_addr_o  = if_addr_i;
            end
        end

        // Responses arriving with nothing outstanding are ignored.
        pop            = mem_rsp_valid_i & (count != '0);
        head_ls        = tag_ls[rd_ptr];
        head_drop      = tag_drop[rd_ptr];
        ls_rsp_valid_o = pop & head_ls;
        if_rsp_valid_o = pop & ~head_ls & ~head_drop & ~flush_i;
        ls_rdata_o     = ls_rsp_valid_o ? mem_rdata_i : '0;
        if_rdata_o     = if_rsp_valid_o ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_ls     <= '0;
            tag_drop   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            lock       <= 1'b0;
            lock_ls    <= 1'b0;
        end else begin
            lock    <= mem_req_valid_o & ~mem_req_ready_i;
            lock_ls <= grant_ls;

            if (!if_req_valid_i) begin
                starve_cnt <= '0;
            end else if (issue) begin
                starve_cnt <= grant_ls ? starve_cnt + SW'(1) : '0;
            end

            if (flush_i) begin
                for (int i = 0; i < MAX_OUTST; i++) begin
                    if (!tag_ls[i]) begin
                        tag_drop[i] <= 1'b1;
                    end
                end
            end

            // The push write follows the flush loop so a same-cycle fetch push keeps its drop.
            if (issue) begin
                tag_ls[wr_ptr]   <= grant_ls;
                tag_drop[wr_ptr] <= flush_i & ~grant_ls;
                wr_ptr           <= wr_ptr + AW'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({issue, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed and randomized checks of imem_port_arbiter against a queue-based model
module tb_imem_port_arbiter;

    localparam int MAX_OUTST    = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid_i = 1'b0;
    logic        if_req_ready_o;
    logic [31:0] if_addr_i = '0;
    logic        if_rsp_valid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_valid_i = 1'b0;
    logic        ls_req_ready_o;
    logic [31:0] ls_addr_i = '0;
    logic        ls_we_i = 1'b0;
    logic [31:0] ls_wdata_i = '0;
    logic [3:0]  ls_wstrb_i = '0;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rdata_o;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    imem_port_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o), .if_addr_i(if_addr_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rdata_o(if_rdata_o),
        .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o), .ls_addr_i(ls_addr_i),
        .ls_we_i(ls_we_i), .ls_wdata_i(ls_wdata_i), .ls_wstrb_i(ls_wstrb_i),
        .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rdata_o(ls_rdata_o),
        .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ls;
        bit drop;
    } ent_t;

    ent_t mq[$];
    int   starve;
    bit   locked;
    bit   lock_ls;
    bit   if_acc;
    bit   ls_acc;
    int   vectors;
    int   miscompares;
    int   n_if_rsp;
    int   n_ls_rsp;
    bit   gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the falling edge: predict outputs from the model, compare, then advance the model.
    task automatic tick();
        bit          full, gls, mv, hs, pop, e_if_rsp, e_ls_rsp;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_wstrb;
        full = (mq.size() == MAX_OUTST);
        if (locked) gls = lock_ls;
        else        gls = ls_req_valid_i && !(if_req_valid_i && starve >= STARVE_LIMIT);
        mv = (gls ? ls_req_valid_i : if_req_valid_i) && !full;
        hs = mv && mem_req_ready_i;
        e_addr = 0; e_we = 0; e_wdata = 0; e_wstrb = 0;
        if (mv && gls) begin
            e_addr = ls_addr_i; e_we = ls_we_i; e_wdata = ls_wdata_i; e_wstrb = ls_wstrb_i;
        end else if (mv) begin
            e_addr = if_addr_i;
        end
        pop      = mem_rsp_valid_i && mq.size() > 0;
        e_ls_rsp = pop && mq[0].ls;
        e_if_rsp = pop && !mq[0].ls && !mq[0].drop && !flush_i;

        chk("mem_req_valid", mem_req_valid_o, mv);
        chk("if_req_ready", if_req_ready_o, !gls && mem_req_ready_i && !full);
        chk("ls_req_ready", ls_req_ready_o, gls && mem_req_ready_i && !full);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("mem_wstrb", mem_wstrb_o, e_wstrb);
        chk("if_rsp_valid", if_rsp_valid_o, e_if_rsp);
        chk("ls_rsp_valid", ls_rsp_valid_o, e_ls_rsp);
        if (e_if_rsp) chk("if_rdata", if_rdata_o, mem_rdata_i);
        if (e_ls_rsp) chk("ls_rdata", ls_rdata_o, mem_rdata_i);

        if (if_rsp_valid_o) n_if_rsp++;
        if (ls_rsp_valid_o) n_ls_rsp++;
        if (ls_req_valid_i && ls_req_ready_o) gq.push_back(1'b1);
        else if (if_req_valid_i && if_req_ready_o) gq.push_back(1'b0);

        if (pop) void'(mq.pop_front());
        if (flush_i) foreach (mq[i]) if (!mq[i].ls) mq[i].drop = 1'b1;
        if (hs) mq.push_back('{ls: gls, drop: flush_i && !gls});
        if (!if_req_valid_i)  starve = 0;
        else if (hs && !gls)  starve = 0;
        else if (hs && gls)   starve = starve + 1;
        locked  = mv && !mem_req_ready_i;
        lock_ls = gls;
        if_acc  = hs && !gls;
        ls_acc  = hs && gls;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        if_req_valid_i = 0; ls_req_valid_i = 0; ls_we_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; flush_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_if_ready", if_req_ready_o, 0);
        chk("rst_ls_ready", ls_req_ready_o, 0);
        chk("rst_if_rsp", if_rsp_valid_o, 0);
        chk("rst_ls_rsp", ls_rsp_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        mq.delete();
        starve = 0; locked = 0; lock_ls = 0; if_acc = 0; ls_acc = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        mem_rsp_valid_i = 1;
        repeat (MAX_OUTST + 1) cyc();
        mem_rsp_valid_i = 0;
        cyc();
    endtask

    initial begin
        bit exp_seq[8];
        vectors = 0; miscompares = 0;
        starve = 0; locked = 0; lock_ls = 0;
        do_reset();

        // Fetch-only stream with one-cycle response latency.
        n_if_rsp = 0; n_ls_rsp = 0;
        mem_req_ready_i = 1;
        if_req_valid_i = 1; if_addr_i = 32'h0; cyc();
        if_addr_i = 32'h4; mem_rsp_valid_i = 1; mem_rdata_i = 32'hA000_0000; cyc();
        if_addr_i = 32'h8; mem_rdata_i = 32'hA000_0004; cyc();
        if_req_valid_i = 0; mem_rdata_i = 32'hA000_0008; cyc();
        mem_rsp_valid_i = 0; cyc();
        chk("fetch_rsp_count", n_if_rsp, 3);
        chk("fetch_ls_rsp_count", n_ls_rsp, 0);

        // Both requesters continuously valid: starvation forces every fourth grant to fetch.
        drain();
        gq.delete();
        mem_req_ready_i = 1; mem_rsp_valid_i = 1;
        if_req_valid_i = 1; if_addr_i = 32'h100;
        ls_req_valid_i = 1; ls_addr_i = 32'h2000; ls_we_i = 0;
        repeat (8) cyc();
        exp_seq = '{1, 1, 1, 0, 1, 1, 1, 0};
        chk("grant_count", gq.size(), 8);
        for (int k = 0; k < 8 && k < gq.size(); k++) chk($sformatf("grant_%0d", k), gq[k], exp_seq[k]);

        // Locked fetch grant survives a stalled port and a late LSU request.
        drain();
        if_req_valid_i = 1; if_addr_i = 32'h40; mem_req_ready_i = 0;
        repeat (3) cyc();
        ls_req_valid_i = 1; ls_addr_i = 32'h200; ls_we_i = 1; ls_wdata_i = 32'hDEAD_BEEF; ls_wstrb_i = 4'hF;
        settle();
        chk("lock_addr_hold", mem_addr_o, 32'h40);
        tick();
        mem_req_ready_i = 1;
        settle();
        chk("lock_fetch_first", if_req_ready_o, 1);
        chk("lock_ls_waits", ls_req_ready_o, 0);
        tick();
        if_req_valid_i = 0;
        settle();
        chk("lock_ls_next", ls_req_ready_o, 1);
        tick();

        // Tag FIFO full blocks issue, including in the cycle a response pops.
        drain();
        mem_req_ready_i = 1; if_req_valid_i = 1;
        for (int k = 0; k < MAX_OUTST; k++) begin
            if_addr_i = 32'h1000 + 4 * k;
            cyc();
        end
        if_addr_i = 32'h1100;
        settle();
        chk("full_valid", mem_req_valid_o, 0);
        chk("full_if_ready", if_req_ready_o, 0);
        chk("full_ls_ready", ls_req_ready_o, 0);
        tick();
        mem_rsp_valid_i = 1;
        settle();
        chk("full_pop_blocks", mem_req_valid_o, 0);
        tick();
        mem_rsp_valid_i = 0;
        settle();
        chk("full_restored", mem_req_valid_o, 1);
        tick();

        // Flush drops both earlier fetch responses but not the store ack between them.
        drain();
        n_if_rsp = 0; n_ls_rsp = 0;
        mem_req_ready_i = 1;
        if_req_valid_i = 1; if_addr_i = 32'h10; cyc();
        if_req_valid_i = 0; ls_req_valid_i = 1; ls_addr_i = 32'h100; ls_we_i = 1;
        ls_wdata_i = 32'h1234_5678; ls_wstrb_i = 4'h3; cyc();
        ls_req_valid_i = 0; if_req_valid_i = 1; if_addr_i = 32'h14; cyc();
        if_req_valid_i = 0; flush_i = 1; cyc();
        flush_i = 0; mem_rsp_valid_i = 1;
        for (int k = 0; k < 3; k++) begin
            mem_rdata_i = 32'hC0DE_0000 + k;
            cyc();
        end
        mem_rsp_valid_i = 0; cyc();
        chk("flush_if_rsp_count", n_if_rsp, 0);
        chk("flush_ls_rsp_count", n_ls_rsp, 1);

        // Reset with requests outstanding, then a fresh fetch is granted at once.
        drain();
        mem_req_ready_i = 1; if_req_valid_i = 1; if_addr_i = 32'h60; cyc();
        if_addr_i = 32'h64; cyc();
        do_reset();
        mem_rsp_valid_i = 1; cyc();
        mem_rsp_valid_i = 0;
        mem_req_ready_i = 1; if_req_valid_i = 1; if_addr_i = 32'h80;
        settle();
        chk("post_rst_grant", if_req_ready_o, 1);
        chk("post_rst_valid", mem_req_valid_o, 1);
        tick();

        // Randomized traffic respecting valid/ready hold rules.
        if_acc = 1; ls_acc = 1;
        for (int n = 0; n < 1500; n++) begin
            if (!if_req_valid_i || if_acc) begin
                if_req_valid_i = ($urandom_range(0, 2) != 0);
                if_addr_i      = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req_valid_i || ls_acc) begin
                ls_req_valid_i = ($urandom_range(0, 2) != 0);
                ls_addr_i      = $urandom;
                ls_we_i        = $urandom_range(0, 1);
                ls_wdata_i     = $urandom;
                ls_wstrb_i     = 4'($urandom);
            end
            mem_req_ready_i = ($urandom_range(0, 3) != 0);
            mem_rsp_valid_i = ($urandom_range(0, 1) != 0);
            mem_rdata_i     = $urandom;
            flush_i         = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
